// File: rtl/regread.sv
// rtl/regread.sv - register-read stage: PRF, writeback bypass, per-lane operand pipeline register
//
// regread_pkg defines iss_bundle_t (opid[15] is the lane valid bit, prsa[0]/prsa[1] are the sources).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   iss_bundle      [iwd] micro-op candidates from the issue queue
//   issue           [iwd] combinational grant back to the issue queue
//   wb_valid/prda/data  [ewd] execute writeback ports into the PRF
//   com_redir       pipeline redirect: kill grants now, flush lanes next edge
//   exe_ready       [iwd] function unit can accept the lane's op
//   rr_valid/bundle/opa/opb  [iwd] pipeline register presented to execute
//   perf_stall, perf_bypass  saturating event counters (only with REGREAD_PERF_EN)
//
// Optional feature macro: REGREAD_PERF_EN

package regread_pkg;
  typedef struct packed {
    logic [15:0]      opid;
    logic [15:0]      prd;
    logic [1:0][15:0] prsa;
  } iss_bundle_t;
endpackage

module regread
  import regread_pkg::*;
#(
  parameter int iwd  = 4,
  parameter int ewd  = 4,
  parameter int nprf = 128,
  parameter int xlen = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  iss_bundle_t [iwd-1:0]         iss_bundle,
  output logic        [iwd-1:0]         issue,
  input  logic        [ewd-1:0]         wb_valid,
  input  logic        [ewd-1:0][15:0]   wb_prda,
  input  logic        [ewd-1:0][xlen-1:0] wb_data,
  input  logic                          com_redir,
  input  logic        [iwd-1:0]         exe_ready,
  output logic        [iwd-1:0]         rr_valid,
  output iss_bundle_t [iwd-1:0]         rr_bundle,
  output logic        [iwd-1:0][xlen-1:0] rr_opa,
  output logic        [iwd-1:0][xlen-1:0] rr_opb
`ifdef REGREAD_PERF_EN
  ,
  output logic        [31:0]            perf_stall,
  output logic        [31:0]            perf_bypass
`endif
);

  localparam int pw = $clog2(nprf);

  logic [xlen-1:0] prf [nprf];

  // Only the low pw bits of a physical address select the register.
  logic unused_prda;
  assign unused_prda = ^wb_prda;

  // PRF: writes land at the edge, so array reads see them from the next cycle.
  // Register 0 is never written and therefore always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < nprf; k++) prf[k] <= '0;
    end else begin
      for (int j = 0; j < ewd; j++) begin
        if (wb_valid[j] && (wb_prda[j][pw-1:0] != '0))
          prf[wb_prda[j][pw-1:0]] <= wb_data[j];
      end
    end
  end

  // Operand read with same-cycle writeback bypass. The bypass excludes
  // register 0 so a dropped write can never leak into a consumer.
  logic [iwd-1:0][1:0][xlen-1:0] opnd;
  logic [iwd-1:0][1:0]           byp;

  always_comb begin
    logic [pw-1:0] idx;
    idx  = '0;
    opnd = '0;
    byp  = '0;
    for (int i = 0; i < iwd; i++) begin
      for (int k = 0; k < 2; k++) begin
        idx        = iss_bundle[i].prsa[k][pw-1:0];
        opnd[i][k] = prf[idx];
        for (int j = 0; j < ewd; j++) begin
          if (wb_valid[j] && (wb_prda[j][pw-1:0] == idx) && (idx != '0)) begin
            opnd[i][k] = wb_data[j];
            byp[i][k]  = 1'b1;
          end
        end
      end
    end
  end

  // Grant: a lane accepts when its slot is empty or being drained this cycle.
  always_comb begin
    issue = '0;
    for (int i = 0; i < iwd; i++) begin
      issue[i] = iss_bundle[i].opid[15] & ~com_redir & ~rst
               & (~rr_valid[i] | exe_ready[i]);
    end
  end

  // Pipeline register. A new grant on a draining lane overwrites the old op
  // in the same edge, so back-to-back ops flow without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_valid  <= '0;
      rr_bundle <= '0;
      rr_opa    <= '0;
      rr_opb    <= '0;
    end else begin
      for (int i = 0; i < iwd; i++) begin
        if (com_redir) begin
          rr_valid[i] <= 1'b0;
        end else if (issue[i]) begin
          rr_valid[i]  <= 1'b1;
          rr_bundle[i] <= iss_bundle[i];
          rr_opa[i]    <= opnd[i][0];
          rr_opb[i]    <= opnd[i][1];
        end else if (exe_ready[i]) begin
          rr_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef REGREAD_PERF_EN
  logic [7:0] stall_inc;
  logic [7:0] byp_inc;

  // Bypass events only count for operands that are actually latched.
  always_comb begin
    stall_inc = '0;
    byp_inc   = '0;
    for (int i = 0; i < iwd; i++) begin
      if (iss_bundle[i].opid[15] && !issue[i]) stall_inc = stall_inc + 8'd1;
      if (issue[i]) begin
        if (byp[i][0]) byp_inc = byp_inc + 8'd1;
        if (byp[i][1]) byp_inc = byp_inc + 8'd1;
      end
    end
  end

  logic [32:0] stall_sum;
  logic [32:0] byp_sum;
  assign stall_sum = {1'b0, perf_stall} + {25'd0, stall_inc};
  assign byp_sum   = {1'b0, perf_bypass} + {25'd0, byp_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall  <= '0;
      perf_bypass <= '0;
    end else begin
      perf_stall  <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
      perf_bypass <= byp_sum[32]   ? 32'hFFFF_FFFF : byp_sum[31:0];
    end
  end
`endif

endmodule

// File: doc/regread.md
Name: regread

Overview:
- Register-read stage between the issue queue and the function units.
- Owns the physical register file (PRF) and writes execute results into it.
- Reads two source operands per issued micro-op, with same-cycle writeback bypass, and latches them into a per-lane pipeline register.
- Drives the per-lane issue grant back to the issue queue and presents operands to execute under a valid/ready handshake.

Parameters:
iwd, 4, issue/read lanes
ewd, 4, writeback ports
nprf, 128, physical registers (power of 2); index = low $clog2(nprf) bits of a 16-bit prd/prs address
xlen, 64, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iss_bundle  in  iwd x iss_bundle_t  candidates from issue queue; lane valid = opid[15]; sources prsa[0], prsa[1]
issue  out  iwd  lane i accepted this cycle; issue queue dequeues on it
wb_valid  in  ewd  writeback valid
wb_prda  in  ewd x 16  writeback destination
wb_data  in  ewd x xlen  writeback value
com_redir  in  1  pipeline redirect (com_bundle[0].redir)
exe_ready  in  iwd  function unit lane i can take an op
rr_valid  out  iwd  pipeline register lane valid
rr_bundle  out  iwd x iss_bundle_t  latched micro-op
rr_opa  out  iwd x xlen  operand for prsa[0]
rr_opb  out  iwd x xlen  operand for prsa[1]

Behaviour:
- Reset: rr_valid=0, rr_bundle=0, rr_opa=0, rr_opb=0; all PRF entries=0. issue is combinational; it is 0 during rst.
- PRF write:
  - A wb_valid[j] write in cycle T is visible to array reads from cycle T+1.
  - Writes to physical reg 0 are dropped; reg 0 always reads 0.
  - Two wb ports writing the same reg in one cycle is illegal; a bench assertion flags it.
- Operand read:
  - Combinational in cycle T: value = PRF[prs].
  - Bypass: if any wb_valid[j] & wb_prda[j]==prs & prs!=0 in the same cycle T, the bypassed wb_data[j] is used instead.
  - Reason: the issue queue wakes consumers on the same-cycle writeback.
- Grant: issue[i] = iss_bundle[i].opid[15] & ~com_redir & ~rst & (~rr_valid[i] | exe_ready[i]).
  - Lanes are independent; there is no cross-lane ordering.
- Pipeline register, per lane, at posedge:
  - if rst|com_redir: rr_valid[i] <= 0.
  - else if issue[i]: rr_valid[i] <= 1; latch bundle and both operands.
  - else if exe_ready[i]: rr_valid[i] <= 0.
  - else: hold.
- Latency: issue in cycle T -> rr_valid at T+1; consumed on any cycle with rr_valid & exe_ready.
- Held operands are not re-snooped. Correct by construction: a source is only woken once its writeback occurs at or before the read cycle.
- Simultaneous drain and refill on one lane (rr_valid & exe_ready & new issue): new op replaces old in the same edge, no bubble.
- Redirect:
  - Grants are suppressed in the redirect cycle; all lanes are invalidated next edge.
  - PRF writes in the redirect cycle still complete.
- rr_bundle/opa/opb are don't-care when rr_valid=0; they are zeroed only on reset.

Optional Feature:
- Macro: REGREAD_PERF_EN.
- When defined, adds outputs perf_stall (32) and perf_bypass (32), both reset to 0, saturating at 2^32-1.
  - perf_stall increments by the number of lanes with iss_bundle valid & ~issue per cycle.
  - perf_bypass increments by the number of operands served from bypass per cycle.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst 1 cycle -> rr_valid=0, issue=0, rr_opa/opb=0 after reset; read of any reg returns 0.
- Basic read: wb p5=0xAB at T0; issue lane0 prsa={5,0} at T2, exe_ready=1 -> issue[0]=1 at T2; rr_valid[0]=1, rr_opa=0xAB, rr_opb=0 at T3.
- Same-cycle bypass: wb_valid[2] p9=0x1234 and lane1 prsa[1]=9 in the same cycle -> rr_opb[1]=0x1234 next cycle.
- Backpressure: rr_valid[0]=1, exe_ready[0]=0, new op on lane0 -> issue[0]=0, register held for 3 cycles. Then exe_ready[0]=1 -> issue[0]=1 and the new op replaces the old with no bubble.
- Redirect: com_redir=1 with 4 valid lanes -> issue=0000 that cycle, rr_valid=0000 next cycle. A wb to p7 in that cycle is still readable afterwards.
- Reg 0: wb p0=0xFF, then read prsa=0 (both array and bypass paths) -> operand 0. With REGREAD_PERF_EN, perf_bypass is unchanged.
